// File: rtl/serial_add_arbiter.sv
// serial_add_arbiter: two clients share one bit-serial full adder under round-robin arbitration.
// Optional: define SERIAL_ADD_OVF_EN to add the signed-overflow output o_ovf.
module serial_add_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_req0,
    input  logic             i_req1,
    input  logic [WIDTH-1:0] i_a0,
    input  logic [WIDTH-1:0] i_b0,
    input  logic [WIDTH-1:0] i_a1,
    input  logic [WIDTH-1:0] i_b1,
    input  logic             i_cin0,
    input  logic             i_cin1,
    output logic             o_gnt0,
    output logic             o_gnt1,
    output logic             o_busy,
    output logic             o_owner,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_done,
    output logic             o_done_id
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             o_ovf
`endif
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_s;
    logic             r_carry;
    logic             r_owner;
    logic             r_last_owner;
    logic             r_gnt0;
    logic             r_gnt1;
    logic             r_done;
    logic             r_done_id;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             w_accept;
    logic             w_pick1;
    logic             w_last;
    logic             w_s;
    logic             w_co;

    // Client 1 wins when alone, or on a tie when client 0 was served last.
    assign w_accept = (r_state == S_IDLE) && (i_req0 || i_req1);
    assign w_pick1  = i_req1 && (!i_req0 || !r_last_owner);
    assign w_last   = r_cnt == CW'(WIDTH - 1);
    assign w_s      = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_co     = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);

    // Sequencing: grant in IDLE, count WIDTH bits in RUN, then pulse done and rotate priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_gnt0       <= 1'b0;
            r_gnt1       <= 1'b0;
            r_done       <= 1'b0;
            r_done_id    <= 1'b0;
        end else begin
            r_gnt0 <= 1'b0;
            r_gnt1 <= 1'b0;
            r_done <= 1'b0;
            if (w_accept) begin
                r_state <= S_RUN;
                r_cnt   <= '0;
                r_owner <= w_pick1;
                r_gnt0  <= !w_pick1;
                r_gnt1  <= w_pick1;
            end else if (r_state == S_RUN) begin
                r_cnt <= r_cnt + 1'b1;
                if (w_last) begin
                    r_state      <= S_IDLE;
                    r_done       <= 1'b1;
                    r_done_id    <= r_owner;
                    r_last_owner <= r_owner;
                end
            end
        end
    end

    // Datapath: load the winner's operands, then add one bit per cycle LSB first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= w_pick1 ? i_a1 : i_a0;
            r_b     <= w_pick1 ? i_b1 : i_b0;
            r_carry <= w_pick1 ? i_cin1 : i_cin0;
        end else if (r_state == S_RUN) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_s     <= {w_s, r_s[WIDTH-1:1]};
            r_carry <= w_co;
            if (w_last) begin
                r_sum  <= {w_s, r_s[WIDTH-1:1]};
                r_cout <= w_co;
            end
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    logic r_ovf;

    // Signed overflow: carry entering the MSB differs from the carry leaving it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_ovf <= 1'b0;
        else if (r_state == S_RUN && w_last)
            r_ovf <= r_carry ^ w_co;
    end

    assign o_ovf = r_ovf;
`endif

    assign o_gnt0    = r_gnt0;
    assign o_gnt1    = r_gnt1;
    assign o_busy    = r_state == S_RUN;
    assign o_owner   = r_owner;
    assign o_sum     = r_sum;
    assign o_cout    = r_cout;
    assign o_done    = r_done;
    assign o_done_id = r_done_id;
endmodule
